// File: rtl/reg_file16.sv
// reg_file16: 8x16 register file, two registered read ports, one write port,
// same-cycle write-to-read bypass and a per-register pending scoreboard.
module reg_file16 #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              rd_busy_a,
   output logic              rd_busy_b,
   output logic              rd_valid
);
   logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];
   logic [DATA_W-1:0]   w_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_pend;
   logic [NUM_REGS-1:0] w_pend_nxt;
   logic                w_wr_ok;
   logic                w_rsv_ok;
   logic                w_byp_a;
   logic                w_byp_b;
   logic [DATA_W-1:0]   w_data_a;
   logic [DATA_W-1:0]   w_data_b;
   assign w_wr_ok  = wr_en && (wr_addr != '0);
   assign w_rsv_ok = rsv_en && (rsv_addr != '0);
   assign w_regs[0] = '0;
   genvar g;
   generate
      for (g = 1; g < NUM_REGS; g++) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_regs[g] <= '0;
            else if (w_wr_ok && wr_addr == ADDR_W'(g)) r_regs[g] <= wr_data;
         end
         assign w_regs[g] = r_regs[g];
      end
      // Reservation is applied after the clear so a same-address issue wins.
      for (g = 0; g < NUM_REGS; g++) begin : g_pend
         assign w_pend_nxt[g] = (r_pend[g] && !(w_wr_ok && wr_addr == ADDR_W'(g)))
                              || (w_rsv_ok && rsv_addr == ADDR_W'(g));
      end
   endgenerate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pend <= '0;
      else r_pend <= w_pend_nxt;
   end
   always_comb begin
      w_byp_a  = w_wr_ok && (wr_addr == rd_addr_a);
      w_byp_b  = w_wr_ok && (wr_addr == rd_addr_b);
      w_data_a = w_byp_a ? wr_data : w_regs[rd_addr_a];
      w_data_b = w_byp_b ? wr_data : w_regs[rd_addr_b];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
         rd_busy_a <= 1'b0;
         rd_busy_b <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data_a <= w_data_a;
            rd_data_b <= w_data_b;
            rd_busy_a <= w_pend_nxt[rd_addr_a];
            rd_busy_b <= w_pend_nxt[rd_addr_b];
         end
      end
   end
endmodule
